// File: rtl/gticc_qpll_reset_ctrl.sv
// QPLL reset initiator for the GTXE2 common block: timed reset pulse, lock-stability wait, retry, fail.
// Define GTICC_LOCKLOSS_CNT_EN to build the saturating lock-loss event counter.
module gticc_qpll_reset_ctrl #(
  parameter int unsigned RESET_PULSE_CYCLES  = 32,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned AUTO_START          = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        qpll_resetdone,
  output logic        qpll_reset,
  output logic        ready,
  output logic        fail,
  output logic        busy,
  output logic [3:0]  attempt,
  output logic [15:0] lockloss_cnt
);

  localparam int unsigned PW = $clog2(RESET_PULSE_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_READY,
    S_FAIL
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pulse_cnt, pulse_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [SW-1:0] stable_cnt, stable_cnt_n;
  logic [3:0]    attempt_n;
  logic          qpll_reset_n, ready_n, fail_n, busy_n;
  logic          new_seq, retry;
  logic          rd_meta, lock_s;

  // Two-flop synchronizer for the asynchronous resetdone
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_meta <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      rd_meta <= qpll_resetdone;
      lock_s  <= rd_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      pulse_cnt  <= '0;
      tmo_cnt    <= '0;
      stable_cnt <= '0;
      attempt    <= '0;
      qpll_reset <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      pulse_cnt  <= pulse_cnt_n;
      tmo_cnt    <= tmo_cnt_n;
      stable_cnt <= stable_cnt_n;
      attempt    <= attempt_n;
      qpll_reset <= qpll_reset_n;
      ready      <= ready_n;
      fail       <= fail_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    pulse_cnt_n  = pulse_cnt;
    tmo_cnt_n    = tmo_cnt;
    stable_cnt_n = stable_cnt;
    attempt_n    = attempt;
    new_seq      = 1'b0;
    retry        = 1'b0;

    case (state)
      S_IDLE: new_seq = (AUTO_START != 0) || start;
      S_ASSERT_RST: begin
        if (pulse_cnt == PW'(RESET_PULSE_CYCLES - 1)) state_n = S_WAIT_LOCK;
        else pulse_cnt_n = pulse_cnt + PW'(1);
      end
      // stable_cnt is zero in WAIT_LOCK, so both states share the run-length logic
      S_WAIT_LOCK, S_STABLE: begin
        tmo_cnt_n = tmo_cnt + TW'(1);
        if (!lock_s) begin
          state_n      = S_WAIT_LOCK;
          stable_cnt_n = '0;
        end else if (stable_cnt == SW'(STABLE_CYCLES - 1)) begin
          state_n      = S_READY;
          stable_cnt_n = SW'(STABLE_CYCLES);
        end else begin
          state_n      = S_STABLE;
          stable_cnt_n = stable_cnt + SW'(1);
        end
        if (state_n != S_READY && tmo_cnt == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (32'(attempt) <= MAX_RETRIES) retry = 1'b1;
          else state_n = S_FAIL;
        end
      end
      S_READY: new_seq = !lock_s || start;
      S_FAIL:  new_seq = start;
      default: state_n = S_IDLE;
    endcase

    // Common entry into a reset pulse
    if (new_seq || retry) begin
      state_n      = S_ASSERT_RST;
      pulse_cnt_n  = '0;
      tmo_cnt_n    = '0;
      stable_cnt_n = '0;
      if (new_seq)               attempt_n = 4'd1;
      else if (attempt != 4'hF)  attempt_n = attempt + 4'd1;
    end

    qpll_reset_n = (state_n == S_IDLE) || (state_n == S_ASSERT_RST) || (state_n == S_FAIL);
    ready_n      = (state_n == S_READY);
    fail_n       = (state_n == S_FAIL);
    busy_n       = (state_n == S_ASSERT_RST) || (state_n == S_WAIT_LOCK) || (state_n == S_STABLE);
  end

`ifdef GTICC_LOCKLOSS_CNT_EN
  logic lockloss_ev;
  assign lockloss_ev = (state == S_READY) && !lock_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lockloss_cnt <= '0;
    else if (lockloss_ev && lockloss_cnt != 16'hFFFF) lockloss_cnt <= lockloss_cnt + 16'd1;
  end
`else
  assign lockloss_cnt = 16'h0000;
`endif

endmodule
